// File: rtl/neuraedge_pkg.sv
// Shared widths, output clamp limits and the stage-3 payload type for the
// requantization pipeline.
package neuraedge_pkg;

  localparam int ACCUM_WIDTH = 32;
  localparam int OUT_WIDTH   = 8;
  localparam int SCALE_WIDTH = 16;
  localparam int SHIFT_WIDTH = 6;
  localparam int CNT_WIDTH   = 16;
  localparam int PROD_WIDTH  = ACCUM_WIDTH + SCALE_WIDTH;
  localparam int MAX_SHIFT   = 47;

  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  // Final-stage payload: requantized activation, tile marker, clamp flag.
  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic                 last;
    logic                 sat;
  } stage_t;

endpackage

// File: rtl/neuraedge_round_sat.sv
// Combinational rounding right shift (round half up), optional ReLU and
// signed clamp to the activation range. Shift is expected already limited
// to MAX_SHIFT by the caller.
module neuraedge_round_sat
  import neuraedge_pkg::*;
(
  input  logic [PROD_WIDTH-1:0]  prod,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   relu,
  output logic [OUT_WIDTH-1:0]   data,
  output logic                   sat
);

  localparam logic signed [PROD_WIDTH:0] MAX_V = (PROD_WIDTH+1)'(OUT_MAX);
  localparam logic signed [PROD_WIDTH:0] MIN_V = (PROD_WIDTH+1)'(OUT_MIN);

  logic signed [PROD_WIDTH:0] ext;
  logic signed [PROD_WIDTH:0] rnd;
  logic signed [PROD_WIDTH:0] shr;
  logic signed [PROD_WIDTH:0] rel;

  // One extra bit keeps the rounding offset from overflowing the product.
  always_comb begin
    ext = $signed({prod[PROD_WIDTH-1], prod});
    if (shift == '0) rnd = ext;
    else             rnd = ext + ((PROD_WIDTH+1)'(1) << (shift - SHIFT_WIDTH'(1)));
    shr = rnd >>> shift;
    rel = (relu && shr[PROD_WIDTH]) ? '0 : shr;
    data = rel[OUT_WIDTH-1:0];
    sat  = 1'b0;
    if (rel > MAX_V) begin
      data = OUT_WIDTH'(OUT_MAX);
      sat  = 1'b1;
    end else if (rel < MIN_V) begin
      data = OUT_WIDTH'(OUT_MIN);
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/neuraedge_requant.sv
// Three-stage valid/ready requantizer: bias add with saturation, unsigned
// scale multiply, then rounding shift / ReLU / clamp. Config lives in shadow
// registers that only load while the pipeline is empty.
module neuraedge_requant
  import neuraedge_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACCUM_WIDTH-1:0] in_accum,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_last,
  input  logic                   cfg_load,
  input  logic [ACCUM_WIDTH-1:0] cfg_bias,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                   cfg_relu,
  output logic                   cfg_err,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   sat_count
);

  logic                   v1, v2, v3;
  logic                   adv1, adv2, adv3;
  logic [ACCUM_WIDTH-1:0] s1_data;
  logic                   s1_last;
  logic [PROD_WIDTH-1:0]  s2_data;
  logic                   s2_last;
  stage_t                 p3;

  logic [ACCUM_WIDTH-1:0] bias;
  logic [SCALE_WIDTH-1:0] scale;
  logic [SHIFT_WIDTH-1:0] shift;
  logic                   relu;

  logic [ACCUM_WIDTH:0]   sum_w;
  logic [ACCUM_WIDTH-1:0] sum_sat;
  logic [PROD_WIDTH-1:0]  prod_w;
  logic [OUT_WIDTH-1:0]   rs_data;
  logic                   rs_sat;
  logic                   cfg_ok;

  assign adv3      = !v3 || out_ready;
  assign adv2      = !v2 || adv3;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign busy      = v1 | v2 | v3;
  assign out_valid = v3;
  assign out_data  = p3.data;
  assign out_last  = p3.last;
  assign cfg_ok    = cfg_load && !busy && !in_valid;

  // 33-bit bias add, clamped back into the signed 32-bit range.
  always_comb begin
    sum_w   = {in_accum[ACCUM_WIDTH-1], in_accum} + {bias[ACCUM_WIDTH-1], bias};
    sum_sat = sum_w[ACCUM_WIDTH-1:0];
    if (sum_w[ACCUM_WIDTH] != sum_w[ACCUM_WIDTH-1])
      sum_sat = {sum_w[ACCUM_WIDTH], {(ACCUM_WIDTH-1){~sum_w[ACCUM_WIDTH]}}};
  end

  assign prod_w = $signed({{SCALE_WIDTH{s1_data[ACCUM_WIDTH-1]}}, s1_data})
                * $signed({{ACCUM_WIDTH{1'b0}}, scale});

  neuraedge_round_sat u_round_sat (
    .prod  (s2_data),
    .shift (shift),
    .relu  (relu),
    .data  (rs_data),
    .sat   (rs_sat)
  );

  // Pipeline registers; each stage moves only when the next one can take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s1_data <= '0;
      s1_last <= 1'b0;
      s2_data <= '0;
      s2_last <= 1'b0;
      p3      <= '0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_data <= sum_sat;
          s1_last <= in_last;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          s2_data <= prod_w;
          s2_last <= s1_last;
        end
      end
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          p3.data <= rs_data;
          p3.last <= s2_last;
          p3.sat  <= rs_sat;
        end
      end
    end
  end

  // Shadow config, load-reject pulse and sticky saturation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias      <= '0;
      scale     <= SCALE_WIDTH'(1);
      shift     <= '0;
      relu      <= 1'b0;
      cfg_err   <= 1'b0;
      sat_count <= '0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      if (cfg_ok) begin
        bias      <= cfg_bias;
        scale     <= cfg_scale;
        shift     <= (cfg_shift > SHIFT_WIDTH'(MAX_SHIFT)) ? SHIFT_WIDTH'(MAX_SHIFT) : cfg_shift;
        relu      <= cfg_relu;
        sat_count <= '0;
      end else if (v3 && out_ready && p3.sat && (sat_count != {CNT_WIDTH{1'b1}})) begin
        sat_count <= sat_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_neuraedge_requant.sv
// Directed and randomized checks of the requantizer against an arithmetic
// reference model with an in-order expected-result queue.
module tb_neuraedge_requant;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_accum;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic               out_last;
  logic               cfg_load;
  logic [31:0]        cfg_bias;
  logic [15:0]        cfg_scale;
  logic [5:0]         cfg_shift;
  logic               cfg_relu;
  logic               cfg_err;
  logic               busy;
  logic [15:0]        sat_count;

  always #5 clk = ~clk;

  neuraedge_requant dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_accum  (in_accum),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .cfg_load  (cfg_load),
    .cfg_bias  (cfg_bias),
    .cfg_scale (cfg_scale),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .sat_count (sat_count)
  );

  typedef struct {
    longint data;
    bit     last;
    bit     sat;
  } exp_t;

  exp_t   q[$];
  int     vectors = 0;
  int     miscompares = 0;
  longint m_bias, m_scale;
  int     m_shift, m_sat, n_out;
  bit     m_relu, acc_f, xfer_f;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_out(input longint accum, input longint bias, input longint scale,
                                     input int sh, input bit relu, output bit sat);
    longint s, p, r;
    s = accum + bias;
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    p = s * scale;
    if (sh == 0) r = p;
    else         r = (p + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    sat = 1'b0;
    if (r > 127)  begin r = 127;  sat = 1'b1; end
    if (r < -128) begin r = -128; sat = 1'b1; end
    return r;
  endfunction

  task automatic cycle();
    exp_t e;
    bit   s;
    @(negedge clk);
    acc_f  = in_valid && in_ready;
    xfer_f = out_valid && out_ready;
    if (xfer_f) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        e = q.pop_front();
        n_out++;
        chk("out_data", out_data, e.data);
        chk("out_last", out_last, e.last);
        if (e.sat && m_sat < 65535) m_sat++;
      end
    end
    if (acc_f) begin
      e.data = ref_out(in_accum, m_bias, m_scale, m_shift, m_relu, s);
      e.last = in_last;
      e.sat  = s;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input longint b, input longint s, input int sh, input bit r);
    bit ok;
    ok        = (q.size() == 0);
    in_valid  = 1'b0;
    cfg_load  = 1'b1;
    cfg_bias  = b[31:0];
    cfg_scale = s[15:0];
    cfg_shift = sh[5:0];
    cfg_relu  = r;
    cycle();
    cfg_load = 1'b0;
    chk("cfg_err", cfg_err, !ok);
    if (ok) begin
      m_bias  = longint'($signed(b[31:0]));
      m_scale = s;
      m_shift = (sh > 47) ? 47 : sh;
      m_relu  = r;
      m_sat   = 0;
    end
  endtask

  task automatic send_word(input longint a, input bit l);
    in_valid = 1'b1;
    in_accum = a[31:0];
    in_last  = l;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc_f) break;
    end
    chk("accept", acc_f, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 10 && !out_valid; i++) cycle();
    chk("out_valid_wait", out_valid, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 30 && q.size() > 0; i++) cycle();
    chk("drained", q.size(), 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int     idx, sent, outs0;
    bit     held;
    longint hold, rb;
    rst_n = 1'b0; in_valid = 1'b0; in_accum = '0; in_last = 1'b0; out_ready = 1'b0;
    cfg_load = 1'b0; cfg_bias = '0; cfg_scale = 16'd1; cfg_shift = '0; cfg_relu = 1'b0;
    m_bias = 0; m_scale = 1; m_shift = 0; m_relu = 0; m_sat = 0; n_out = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Scale 3, shift 5 on +1000, with exact latency.
    out_ready = 1'b1;
    do_load(0, 3, 5, 0);
    in_valid = 1'b1; in_accum = 32'sd1000; in_last = 1'b0;
    cycle();
    chk("t1_accept", acc_f, 1);
    in_valid = 1'b0;
    cycle();
    chk("t1_lat2", out_valid, 0);
    cycle();
    chk("t1_lat3", out_valid, 1);
    chk("t1_data", out_data, 94);
    drain();
    chk("t1_sat_count", sat_count, 0);

    // Negative value, then ReLU.
    out_ready = 1'b0;
    send_word(-1000, 0);
    wait_out();
    chk("t2_data", out_data, -94);
    drain();
    do_load(0, 3, 5, 1);
    out_ready = 1'b0;
    send_word(-1000, 1);
    wait_out();
    chk("t2_relu", out_data, 0);
    drain();
    chk("t2_sat_count", sat_count, 0);

    // Bias add saturates in stage 1.
    do_load(256, 1, 0, 0);
    out_ready = 1'b0;
    send_word(64'sh7FFFFFF0, 0);
    wait_out();
    chk("t3_data", out_data, 127);
    drain();
    chk("t3_sat_count", sat_count, 1);

    // Backpressure: three words buffered, then ordered release.
    do_load(0, 1, 0, 0);
    out_ready = 1'b0;
    idx = 0; held = 0; hold = 0; outs0 = n_out;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 6); in_accum = 32'(idx + 1); in_last = (idx == 5);
      cycle();
      if (acc_f) idx++;
      if (out_valid) begin
        if (!held) begin hold = out_data; held = 1; end
        else chk("t4_stable", out_data, hold);
      end
    end
    chk("t4_accepts", idx, 3);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_head", hold, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      in_valid = 1'b1; in_accum = 32'(idx + 1); in_last = (idx == 5);
      cycle();
      if (acc_f) idx++;
    end
    in_valid = 1'b0;
    chk("t4_all_in", idx, 6);
    drain();
    chk("t4_out_count", n_out - outs0, 6);

    // Load rejected while busy.
    out_ready = 1'b0;
    send_word(1000, 0);
    do_load(0, 5, 0, 0);
    cycle();
    chk("t5_err_pulse", cfg_err, 0);
    send_word(20, 0);
    drain();
    chk("t5_sat_count", sat_count, 1);

    // Shift above 47 behaves as 47.
    do_load(0, 16'hFFFF, 63, 0);
    out_ready = 1'b0;
    send_word(64'sh7FFFFFFF, 0);
    wait_out();
    chk("t6_shift_clamp", out_data, 1);
    drain();

    // Randomized traffic with occasional config requests.
    for (int k = 0; k < 4; k++) begin
      drain();
      rb = longint'($urandom_range(0, 2000)) - 1000;
      do_load(rb, longint'($urandom_range(0, 65535)),
              (k == 3) ? int'($urandom_range(0, 63)) : int'($urandom_range(8, 30)),
              bit'($urandom_range(0, 1)));
      sent = 0;
      for (int n = 0; n < 300 && sent < 30; n++) begin
        if ($urandom_range(0, 19) == 0) begin
          do_load(rb, longint'($urandom_range(0, 65535)), int'($urandom_range(0, 40)), 1'b0);
        end
        in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) in_accum = $urandom;
        else in_accum = 32'(int'($urandom_range(0, 4000)) - 2000);
        in_last   = ($urandom_range(0, 7) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
        cycle();
        if (acc_f) sent++;
      end
      in_valid = 1'b0;
      chk("rand_sent", sent, 30);
      drain();
      chk("rand_sat_count", sat_count, m_sat);
    end

    // Async reset with words in flight.
    do_load(0, 7, 0, 0);
    send_word(100, 0);
    drain();
    chk("t7_sat_before", sat_count, 1);
    out_ready = 1'b0;
    send_word(1, 0);
    send_word(2, 1);
    chk("t7_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", out_valid, 0);
    chk("t7_rst_sat", sat_count, 0);
    chk("t7_rst_busy", busy, 0);
    q.delete();
    m_bias = 0; m_scale = 1; m_shift = 0; m_relu = 0; m_sat = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("t7_no_stale", out_valid, 0);
    out_ready = 1'b0;
    send_word(-5, 0);
    wait_out();
    chk("t7_data", out_data, -5);
    drain();
    repeat (4) cycle();
    chk("t7_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
